// File: rtl/execute_muldiv_seq.sv
// rtl/execute_muldiv_seq.sv - iterative mul/div sequencer for the execute stage
module execute_muldiv_seq #(
  parameter int LEN_REG     = 32,
  parameter int LEN_OPECODE = 7,
  parameter int LEN_CNT     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   stall_o,
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_REG-1:0]     data_rd,
  input  logic [LEN_REG-1:0]     data_rs,
  output logic                   valid_o,
  input  logic                   stall_i,
  output logic [LEN_REG-1:0]     data_o,
  output logic                   busy
);

  localparam logic [LEN_OPECODE-1:0] OP_MUL = LEN_OPECODE'(2);
  localparam logic [LEN_OPECODE-1:0] OP_DIV = LEN_OPECODE'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [LEN_CNT-1:0] cnt;
  logic               op_div;
  // mcand holds multiplicand (mul) or the dividend being shifted out (div);
  // mplier holds multiplier (mul) or divisor (div); acc is product or quotient.
  logic [LEN_REG-1:0] mcand, mplier, acc, rem;
  logic [LEN_REG-1:0] mcand_step, mplier_step, acc_step, rem_step;
  logic [LEN_REG:0]   rem_shift;
  logic               accept, finish;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // next-state decode and accept/finish strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_i && (opecode == OP_MUL || opecode == OP_DIV)) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // one iteration of shift-add multiply or restoring divide
  always_comb begin
    mcand_step  = mcand << 1;
    mplier_step = mplier;
    acc_step    = acc;
    rem_step    = rem;
    rem_shift   = {rem, mcand[LEN_REG-1]};
    if (!op_div) begin
      mplier_step = mplier >> 1;
      if (mplier[0]) acc_step = acc + mcand;
    end else if (rem_shift >= {1'b0, mplier}) begin
      // difference is below the divisor, so the low bits carry it exactly
      rem_step = rem_shift[LEN_REG-1:0] - mplier;
      acc_step = {acc[LEN_REG-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[LEN_REG-1:0];
      acc_step = {acc[LEN_REG-2:0], 1'b0};
    end
  end

  // operand/iteration datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      rem     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= LEN_CNT'(LEN_REG - 1);
        op_div <= (opecode == OP_DIV);
        mcand  <= data_rd;
        mplier <= data_rs;
        acc    <= '0;
        rem    <= '0;
      end else if (state == S_RUN) begin
        mcand  <= mcand_step;
        mplier <= mplier_step;
        acc    <= acc_step;
        rem    <= rem_step;
        if (!finish) cnt <= cnt - 1'b1;
      end
      if (finish) begin
        data_o  <= acc_step;
        valid_o <= 1'b1;
      end else if (state == S_DONE && !stall_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // stall is a pure decode of the state register, never of valid_i
  assign stall_o = (state != S_IDLE);
  assign busy    = stall_o;

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// tb/tb_execute_muldiv_seq.sv - scoreboard bench for execute_muldiv_seq
module tb_execute_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        stall_o;
  logic [6:0]  opecode = 7'd0;
  logic [31:0] data_rd = 32'd0;
  logic [31:0] data_rs = 32'd0;
  logic        valid_o;
  logic        stall_i = 1'b0;
  logic [31:0] data_o;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] q[$];

  localparam logic [6:0] MUL = 7'b000_0010;
  localparam logic [6:0] DIV = 7'b000_0011;

  execute_muldiv_seq #(.LEN_REG(32), .LEN_OPECODE(7), .LEN_CNT(6)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o),
    .opecode(opecode), .data_rd(data_rd), .data_rs(data_rs),
    .valid_o(valid_o), .stall_i(stall_i), .data_o(data_o), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] rd,
                        input logic [31:0] rs, input logic [31:0] exp, input int hold,
                        output int acc_cyc);
    int n;
    logic [31:0] want;
    stall_i = (hold > 0);
    @(negedge clk);
    valid_i = 1'b1; opecode = op; data_rd = rd; data_rs = rs;
    q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0; opecode = 7'd0;
    @(negedge clk);
    check({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!valid_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 32'd32);
    want = q.pop_front();
    check({tag, "_data"}, data_o, want);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_hold_data"}, data_o, want);
      check({tag, "_hold_stall"}, {31'd0, stall_o}, 32'd1);
    end
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_idle_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  initial begin
    int c0, c1;
    #1;
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", data_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("mul_7x6", MUL, 32'd7, 32'd6, 32'd42, 0, c0);
    run_op("mul_max2", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0, c0);
    run_op("mul_trunc", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 0, c0);
    run_op("div_100_7_hold", DIV, 32'd100, 32'd7, 32'd14, 5, c0);
    run_op("div_max_1", DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, c0);
    run_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, c0);
    run_op("div_0_9", DIV, 32'd0, 32'd9, 32'd0, 0, c0);
    run_op("mul_big", MUL, 32'h1234_5678, 32'h9ABC_DEF1, 32'h1234_5678 * 32'h9ABC_DEF1, 0, c0);

    // reset in the middle of a multiply; data_o still holds a prior result
    run_op("div_200_3", DIV, 32'd200, 32'd3, 32'd66, 0, c0);
    @(negedge clk);
    valid_i = 1'b1; opecode = MUL; data_rd = 32'd3; data_rs = 32'd3;
    @(posedge clk);
    #1;
    valid_i = 1'b0; opecode = 7'd0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_result", {31'd0, valid_o}, 32'd0);
    run_op("div_9_3", DIV, 32'd9, 32'd3, 32'd3, 0, c0);

    // unsupported opecode is ignored
    @(negedge clk);
    valid_i = 1'b1; opecode = 7'b000_0000; data_rd = 32'd4; data_rs = 32'd4;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("badop_stall", {31'd0, stall_o}, 32'd0);
      check("badop_valid", {31'd0, valid_o}, 32'd0);
    end

    // back-to-back multiplies
    run_op("b2b_2x3", MUL, 32'd2, 32'd3, 32'd6, 0, c0);
    run_op("b2b_4x5", MUL, 32'd4, 32'd5, 32'd20, 0, c1);
    check("b2b_spacing", c1 - c0, 32'd34);
    check("queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
